rocket_control: RTL

// Player-rocket controller. Launches one rocket on fire, flies it up at a fixed x, and checks it against the active enemy.

---
 rtl/rocket_control.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rocket_control.sv
// ---------------------------------------------------------------------------
// rocket_control
//
// Player-rocket controller. A launch request in IDLE captures the aim x
// position and starts a rocket at Y_ROCKET_START. The rocket climbs one
// pixel per speed_pulse at a fixed x until it either overlaps the active
// enemy (hit) or reaches Y_ROCKET_END (miss). A hit produces a single-cycle
// rockethit pulse for the enemy controller. Both outcomes are followed by a
// cooldown of COOLDOWN_TIME speed_pulses before a new launch is accepted.
//
// Ports
//   clk           in   1             clock
//   rst           in   1             synchronous, active-high reset
//   fire          in   1             launch request, level-sampled in IDLE
//   x_aim         in   OUT_WIDTH     launch x, captured on accepted fire
//   speed_pulse   in   1             one-cycle movement tick
//   enemy_spawn   in   1             enemy visible/active
//   xenemy        in   OUT_WIDTH     enemy x
//   yenemy        in   OUT_WIDTH     enemy y
//   xrocket       out  OUT_WIDTH     rocket x (registered)
//   yrocket       out  OUT_WIDTH     rocket y (registered)
//   rocket_spawn  out  1             rocket drawn (registered)
//   rockethit     out  1             one-cycle hit pulse to enemy (registered)
//   adr_rocket    out  ADDRESSWIDTH  ROM start address of the rocket image
//   ready         out  1             high while the controller is in IDLE
// ---------------------------------------------------------------------------
module rocket_control #(
  parameter int OUT_WIDTH        = 8,
  parameter int ADDRESSWIDTH     = 10,
  parameter int X_BASE           = 128,
  parameter int Y_ROCKET_START   = 16,
  parameter int Y_ROCKET_END     = 200,
  parameter int HIT_RADIUS       = 4,
  parameter int COOLDOWN_TIME    = 3,
  parameter int ADR_ROCKET_START = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fire,
  input  logic [OUT_WIDTH-1:0]    x_aim,
  input  logic                    speed_pulse,
  input  logic                    enemy_spawn,
  input  logic [OUT_WIDTH-1:0]    xenemy,
  input  logic [OUT_WIDTH-1:0]    yenemy,
  output logic [OUT_WIDTH-1:0]    xrocket,
  output logic [OUT_WIDTH-1:0]    yrocket,
  output logic                    rocket_spawn,
  output logic                    rockethit,
  output logic [ADDRESSWIDTH-1:0] adr_rocket,
  output logic                    ready
);

  // Cooldown counter must hold COOLDOWN_TIME; keep at least one bit.
  localparam int CNT_W = (COOLDOWN_TIME < 2) ? 1 : $clog2(COOLDOWN_TIME + 1);

  localparam logic [OUT_WIDTH-1:0]    X_BASE_C  = OUT_WIDTH'(X_BASE);
  localparam logic [OUT_WIDTH-1:0]    Y_START_C = OUT_WIDTH'(Y_ROCKET_START);
  localparam logic [OUT_WIDTH-1:0]    Y_END_C   = OUT_WIDTH'(Y_ROCKET_END);
  localparam logic [OUT_WIDTH:0]      HIT_R_C   = (OUT_WIDTH + 1)'(HIT_RADIUS);
  localparam logic [CNT_W-1:0]        CD_C      = CNT_W'(COOLDOWN_TIME);
  localparam logic [ADDRESSWIDTH-1:0] ADR_C     = ADDRESSWIDTH'(ADR_ROCKET_START);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_FLY      = 3'd2,
    ST_HIT      = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [OUT_WIDTH-1:0]    x_q, x_d;
  logic [OUT_WIDTH-1:0]    y_q, y_d;
  logic                    spawn_q, spawn_d;
  logic                    hit_q, hit_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDRESSWIDTH-1:0] adr_q;
  logic                    hit_s;

  // Absolute difference in one extra bit so that no operand order can wrap.
  function automatic logic [OUT_WIDTH:0] abs_diff(
    input logic [OUT_WIDTH-1:0] a,
    input logic [OUT_WIDTH-1:0] b
  );
    logic [OUT_WIDTH:0] r;
    if (a >= b) begin
      r = {1'b0, a} - {1'b0, b};
    end else begin
      r = {1'b0, b} - {1'b0, a};
    end
    return r;
  endfunction

  // Overlap test against the enemy, using the registered rocket position.
  always_comb begin
    hit_s = 1'b0;
    if (enemy_spawn &&
        (abs_diff(x_q, xenemy) <= HIT_R_C) &&
        (abs_diff(y_q, yenemy) <= HIT_R_C)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Next-state and next-output logic for the launch/flight/cooldown cycle.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    spawn_d = spawn_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      ST_RESET: begin
        state_d = ST_IDLE;
        x_d     = X_BASE_C;
        y_d     = Y_START_C;
        spawn_d = 1'b0;
      end

      ST_IDLE: begin
        spawn_d = 1'b0;
        y_d     = Y_START_C;
        if (fire) begin
          state_d = ST_FLY;
          x_d     = x_aim;
          spawn_d = 1'b1;
        end else begin
          x_d     = X_BASE_C;
        end
      end

      ST_FLY: begin
        // Hit wins over the miss ceiling, so a hit at Y_ROCKET_END still counts.
        if (hit_s) begin
          state_d = ST_HIT;
          hit_d   = 1'b1;
          spawn_d = 1'b0;
        end else if (y_q >= Y_END_C) begin
          state_d = ST_COOLDOWN;
          cnt_d   = CD_C;
          spawn_d = 1'b0;
        end else if (speed_pulse) begin
          y_d = y_q + OUT_WIDTH'(1);
        end else begin
          y_d = y_q;
        end
      end

      ST_HIT: begin
        // rockethit is high for this one cycle only; hit_d defaults low.
        state_d = ST_COOLDOWN;
        cnt_d   = CD_C;
        spawn_d = 1'b0;
      end

      ST_COOLDOWN: begin
        spawn_d = 1'b0;
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
          x_d     = X_BASE_C;
          y_d     = Y_START_C;
        end else if (speed_pulse) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        // Unreachable encodings recover through RESET with idle outputs.
        state_d = ST_RESET;
        x_d     = X_BASE_C;
        y_d     = Y_START_C;
        spawn_d = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      x_q     <= X_BASE_C;
      y_q     <= Y_START_C;
      spawn_q <= 1'b0;
      hit_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      adr_q   <= ADR_C;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      spawn_q <= spawn_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      adr_q   <= ADR_C;
    end
  end

  assign xrocket      = x_q;
  assign yrocket      = y_q;
  assign rocket_spawn = spawn_q;
  assign rockethit    = hit_q;
  assign adr_rocket   = adr_q;
  assign ready        = (state_q == ST_IDLE);

endmodule
